// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// state encoding, opcode constants and the legal-opcode decode helper.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Width of the memory wait counter; limits TIMEOUT_CYCLES to 255.
  localparam int TIMER_W = 8;

  // True for the five opcodes the sequencer knows how to execute.
  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: is_legal_op = 1'b1;
      default:                                 is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the sequencer (master) and the datapath/memory side (slave).
interface mips_multicycle_ctrl_if;

  logic       start;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       reg_write;
  logic       wb_sel;
  logic       busy;
  logic [2:0] state;
  logic       illegal;
  logic       timeout;

  modport master (
    input  start, opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           reg_write, wb_sel, busy, state, illegal, timeout
  );

  modport slave (
    output start, opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           reg_write, wb_sel, busy, state, illegal, timeout
  );

endinterface

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle in which the
// wait would reach TIMEOUT_CYCLES, so the FSM can halt instead of completing.
module mem_wait_timer
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LIMIT_M1 = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  // Next count: clear on entry to a wait state, otherwise count stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {TIMER_W{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {TIMER_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This stalled cycle is the one that would bring the count to the limit.
  assign expired = en && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: walks each instruction through
// fetch/decode/execute/memory/write-back and halts on illegal opcodes or
// memory timeouts.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic                   clk,
  input logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       busy_q, busy_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;

  logic mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, wb_sel;
  logic wait_en, wait_clr, wait_expired;

  // A stalled memory cycle: in a memory state with the access not yet done.
  assign wait_en  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready;
  // Restart the wait count whenever a memory state is newly entered.
  assign wait_clr = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (wait_clr),
    .en     (wait_en),
    .expired(wait_expired)
  );

  // Next-state and control decode; FETCH enables are Mealy on mem_ready.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        op_d = bus.opcode;
        if (is_legal_op(bus.opcode)) begin
          state_d = ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_RTYPE, OP_ADDI: state_d = ST_WB;
          OP_LW, OP_SW:      state_d = ST_MEM;
          OP_BEQ: begin
            pc_src   = 1'b1;
            pc_write = bus.zero;
            state_d  = ST_FETCH;
          end
          default:           state_d = ST_HALT;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (op_q == OP_SW);
        if (bus.mem_ready) begin
          if (op_q == OP_LW) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (op_q == OP_LW);
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_HALT);
  end

  // State, captured opcode, registered busy and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 6'd0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.iord      = iord;
  assign bus.ir_write  = ir_write;
  assign bus.pc_write  = pc_write;
  assign bus.pc_src    = pc_src;
  assign bus.reg_write = reg_write;
  assign bus.wb_sel    = wb_sel;
  assign bus.busy      = busy_q;
  assign bus.state     = state_q;
  assign bus.illegal   = illegal_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the stimulus process pushes the
// hand-computed output vector expected in each cycle, the monitor pops and
// compares it on the falling edge.
module tb_mips_multicycle_ctrl;

  logic clk;
  logic reset;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl #(
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  localparam logic [5:0] R_OP  = 6'b000000;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BAD   = 6'b111111;

  // {state, busy, mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, wb_sel, illegal, timeout}
  localparam logic [13:0] E_IDLE = {3'd0, 11'b0};
  localparam logic [13:0] E_FW   = {3'd1, 1'b1, 1'b1, 7'b0, 2'b00};
  localparam logic [13:0] E_FD   = {3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [13:0] E_D    = {3'd2, 1'b1, 8'b0, 2'b00};
  localparam logic [13:0] E_E    = {3'd3, 1'b1, 8'b0, 2'b00};
  localparam logic [13:0] E_EBZ  = {3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
  localparam logic [13:0] E_EBN  = {3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
  localparam logic [13:0] E_MLW  = {3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [13:0] E_MSW  = {3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [13:0] E_WA   = {3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
  localparam logic [13:0] E_WL   = {3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
  localparam logic [13:0] E_HILL = {3'd6, 9'b0, 2'b10};
  localparam logic [13:0] E_HTO  = {3'd6, 9'b0, 2'b01};

  logic [13:0] exp_q[$];
  int          id_q[$];
  int          step_no = 0;
  int          checks  = 0;
  int          errors  = 0;

  logic [13:0] act_v;
  logic [13:0] exp_v;
  int          id_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic s, input logic [5:0] op, input logic z,
                      input logic mr, input logic [13:0] ex);
    bus.start     = s;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = mr;
    exp_q.push_back(ex);
    id_q.push_back(step_no);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT outputs against the queued expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      id_v  = id_q.pop_front();
      act_v = {bus.state, bus.busy, bus.mem_req, bus.mem_we, bus.iord,
               bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write,
               bus.wb_sel, bus.illegal, bus.timeout};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL step%0d outputs: got %b expected %b", id_v, act_v, exp_v);
      end
    end
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.opcode    = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, R_OP, 1'b0, 1'b1, E_IDLE);   // reset state
    reset = 1'b0;

    // R-type with immediate memory: 0,1,2,3,5 then back to FETCH
    step(1'b1, R_OP, 1'b0, 1'b1, E_IDLE);
    step(1'b0, R_OP, 1'b0, 1'b1, E_FD);
    step(1'b0, R_OP, 1'b0, 1'b1, E_D);
    step(1'b0, R_OP, 1'b0, 1'b1, E_E);
    step(1'b0, R_OP, 1'b0, 1'b1, E_WA);

    // lw with three MEM wait cycles: 8 cycles total
    step(1'b0, LW, 1'b0, 1'b1, E_FD);
    step(1'b0, LW, 1'b0, 1'b1, E_D);
    step(1'b0, LW, 1'b0, 1'b1, E_E);
    for (int i = 0; i < 3; i++) step(1'b0, LW, 1'b0, 1'b0, E_MLW);
    step(1'b0, LW, 1'b0, 1'b1, E_MLW);
    step(1'b0, LW, 1'b0, 1'b1, E_WL);

    // beq taken then not taken
    step(1'b0, BEQ, 1'b0, 1'b1, E_FD);
    step(1'b0, BEQ, 1'b0, 1'b1, E_D);
    step(1'b0, BEQ, 1'b1, 1'b1, E_EBZ);
    step(1'b0, BEQ, 1'b0, 1'b1, E_FD);
    step(1'b0, BEQ, 1'b0, 1'b1, E_D);
    step(1'b0, BEQ, 1'b0, 1'b1, E_EBN);

    // addi, then sw with immediate memory
    step(1'b0, ADDI, 1'b0, 1'b1, E_FD);
    step(1'b0, ADDI, 1'b0, 1'b1, E_D);
    step(1'b0, ADDI, 1'b0, 1'b1, E_E);
    step(1'b0, ADDI, 1'b0, 1'b1, E_WA);
    step(1'b0, SW, 1'b0, 1'b1, E_FD);
    step(1'b0, SW, 1'b0, 1'b1, E_D);
    step(1'b0, SW, 1'b0, 1'b1, E_E);
    step(1'b0, SW, 1'b0, 1'b1, E_MSW);

    // mem_ready arriving on the 15th FETCH cycle still completes normally
    for (int i = 0; i < 14; i++) step(1'b0, R_OP, 1'b0, 1'b0, E_FW);
    step(1'b0, R_OP, 1'b0, 1'b1, E_FD);
    step(1'b0, R_OP, 1'b0, 1'b1, E_D);
    step(1'b0, R_OP, 1'b0, 1'b1, E_E);
    step(1'b0, R_OP, 1'b0, 1'b1, E_WA);

    // 15 stalled FETCH cycles: timeout halt, start ignored in HALT
    for (int i = 0; i < 15; i++) step(1'b0, R_OP, 1'b0, 1'b0, E_FW);
    for (int i = 0; i < 4; i++) step(i[0], R_OP, 1'b0, 1'b1, E_HTO);
    reset = 1'b1;
    step(1'b0, R_OP, 1'b0, 1'b0, E_IDLE);
    reset = 1'b0;

    // illegal opcode: DECODE -> HALT, sticky illegal, start ignored
    step(1'b1, BAD, 1'b0, 1'b1, E_IDLE);
    step(1'b0, BAD, 1'b0, 1'b1, E_FD);
    step(1'b0, BAD, 1'b0, 1'b1, E_D);
    for (int i = 0; i < 4; i++) step(i[0], BAD, 1'b0, 1'b1, E_HILL);
    reset = 1'b1;
    step(1'b0, R_OP, 1'b0, 1'b0, E_IDLE);
    reset = 1'b0;

    // reset asserted mid-cycle during a stalled sw MEM access
    step(1'b1, SW, 1'b0, 1'b0, E_IDLE);
    step(1'b0, SW, 1'b0, 1'b1, E_FD);
    step(1'b0, SW, 1'b0, 1'b1, E_D);
    step(1'b0, SW, 1'b0, 1'b1, E_E);
    step(1'b0, SW, 1'b0, 1'b0, E_MSW);
    reset = 1'b1;
    step(1'b0, SW, 1'b0, 1'b0, E_IDLE);
    step(1'b0, SW, 1'b0, 1'b1, E_IDLE);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, R_OP, 1'b0, 1'b1, E_IDLE);
    step(1'b1, R_OP, 1'b0, 1'b1, E_IDLE);
    step(1'b0, R_OP, 1'b0, 1'b1, E_FD);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
